// File: rtl/pid_increment.sv
// Incremental PID controller: u(k) = u(k-1) + ((kp*dE + ki*e0 + kd*d2E) >>> FRAC).
// One shared signed multiplier is stepped over the P, I and D terms, then the sum is saturated.
//
// state | meaning
// IDLE  | waiting for start; operands are captured when start is accepted
// MP    | acc <= kp*(e0-e1)
// MI    | acc <= acc + ki*e0
// MD    | acc <= acc + kd*(e0-2*e1+e2)
// SUM   | u_out <= saturate(u_out + (acc >>> FRAC)), pulse valid
module pid_increment #(
  parameter int ERR_W = 10,
  parameter int K_W   = 8,
  parameter int FRAC  = 4,
  parameter int U_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    clr,
  input  logic signed [ERR_W-1:0] ek0,
  input  logic signed [ERR_W-1:0] ek1,
  input  logic signed [ERR_W-1:0] ek2,
  input  logic signed [K_W-1:0]   kp,
  input  logic signed [K_W-1:0]   ki,
  input  logic signed [K_W-1:0]   kd,
  output logic signed [U_W-1:0]   u_out,
  output logic                    valid,
  output logic                    busy,
  output logic                    sat
);

  localparam int D1_W   = ERR_W + 1;
  localparam int D2_W   = ERR_W + 2;
  localparam int PROD_W = K_W + D2_W;
  localparam int ACC_W  = ERR_W + K_W + 4;
  localparam int SHF_W  = ACC_W - FRAC;
  localparam int SUM_W  = ((U_W > SHF_W) ? U_W : SHF_W) + 1;

  localparam logic signed [SUM_W-1:0] U_MAX = SUM_W'((64'sd1 <<< (U_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] U_MIN = -U_MAX - SUM_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MP   = 3'd1,
    S_MI   = 3'd2,
    S_MD   = 3'd3,
    S_SUM  = 3'd4
  } state_t;

  state_t                    r_state;
  logic signed [ERR_W-1:0]   r_e0, r_e1, r_e2;
  logic signed [K_W-1:0]     r_kp, r_ki, r_kd;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [U_W-1:0]     r_u;
  logic                      r_valid;
  logic                      r_sat;

  logic signed [D1_W-1:0]    w_d1;
  logic signed [D2_W-1:0]    w_d2;
  logic signed [K_W-1:0]     w_mul_k;
  logic signed [D2_W-1:0]    w_mul_e;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [SHF_W-1:0]   w_shift;
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [U_W-1:0]     w_u_next;
  logic                      w_sat_next;

  // Differences are formed from the captured operands at widths that cannot overflow.
  assign w_d1 = D1_W'(r_e0) - D1_W'(r_e1);
  assign w_d2 = D2_W'(r_e0) - (D2_W'(r_e1) <<< 1) + D2_W'(r_e2);

  always_comb begin
    w_mul_k = r_kp;
    w_mul_e = D2_W'(w_d1);
    case (r_state)
      S_MI: begin
        w_mul_k = r_ki;
        w_mul_e = D2_W'(r_e0);
      end
      S_MD: begin
        w_mul_k = r_kd;
        w_mul_e = w_d2;
      end
      default: begin
        w_mul_k = r_kp;
        w_mul_e = D2_W'(w_d1);
      end
    endcase
  end

  assign w_prod = w_mul_k * w_mul_e;

  // Arithmetic shift gives floor rounding; the sum is clipped at full width.
  assign w_shift = SHF_W'(r_acc >>> FRAC);
  assign w_sum   = SUM_W'(r_u) + SUM_W'(w_shift);

  always_comb begin
    w_u_next   = U_W'(w_sum);
    w_sat_next = 1'b0;
    if (w_sum > U_MAX) begin
      w_u_next   = U_W'(U_MAX);
      w_sat_next = 1'b1;
    end else if (w_sum < U_MIN) begin
      w_u_next   = U_W'(U_MIN);
      w_sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_e0    <= '0;
      r_e1    <= '0;
      r_e2    <= '0;
      r_kp    <= '0;
      r_ki    <= '0;
      r_kd    <= '0;
      r_acc   <= '0;
      r_u     <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else if (clr) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_u     <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_e0    <= ek0;
            r_e1    <= ek1;
            r_e2    <= ek2;
            r_kp    <= kp;
            r_ki    <= ki;
            r_kd    <= kd;
            r_state <= S_MP;
          end
        end
        S_MP: begin
          r_acc   <= ACC_W'(w_prod);
          r_state <= S_MI;
        end
        S_MI: begin
          r_acc   <= r_acc + ACC_W'(w_prod);
          r_state <= S_MD;
        end
        S_MD: begin
          r_acc   <= r_acc + ACC_W'(w_prod);
          r_state <= S_SUM;
        end
        S_SUM: begin
          r_u     <= w_u_next;
          r_sat   <= w_sat_next;
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign u_out = r_u;
  assign valid = r_valid;
  assign busy  = (r_state != S_IDLE);
  assign sat   = r_sat;

endmodule

// File: tb/tb_pid_increment.sv
// Self-checking bench for pid_increment: a cycle-level behavioural model of the
// incremental PID law is compared against the DUT every cycle, plus directed literal cases.
module tb_pid_increment;

  localparam int ERR_W = 10;
  localparam int K_W   = 8;
  localparam int FRAC  = 4;
  localparam int U_W   = 16;
  localparam int LAT   = 4;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic                    clr;
  logic signed [ERR_W-1:0] ek0, ek1, ek2;
  logic signed [K_W-1:0]   kp, ki, kd;
  logic signed [U_W-1:0]   u_out;
  logic                    valid;
  logic                    busy;
  logic                    sat;

  int n_chk = 0;
  int n_err = 0;

  pid_increment #(.ERR_W(ERR_W), .K_W(K_W), .FRAC(FRAC), .U_W(U_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .clr   (clr),
    .ek0   (ek0),
    .ek1   (ek1),
    .ek2   (ek2),
    .kp    (kp),
    .ki    (ki),
    .kd    (kd),
    .u_out (u_out),
    .valid (valid),
    .busy  (busy),
    .sat   (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the result of an accepted start is known immediately from
  // the PID law; it appears LAT edges later unless rst/clr intervene.
  longint m_u, m_res;
  bit     m_sat, m_res_sat, m_valid, m_en;
  int     m_cnt;

  function automatic void pid_law(input longint u0, output longint res, output bit clip);
    longint e0, e1, e2, p, i, d, inc, s, umax, umin;
    e0 = longint'(ek0); e1 = longint'(ek1); e2 = longint'(ek2);
    p  = longint'(kp);  i  = longint'(ki);  d  = longint'(kd);
    inc  = p * (e0 - e1) + i * e0 + d * (e0 - 2 * e1 + e2);
    s    = u0 + (inc >>> FRAC);
    umax = (64'sd1 <<< (U_W - 1)) - 1;
    umin = -umax - 1;
    clip = 1'b0;
    res  = s;
    if (s > umax) begin res = umax; clip = 1'b1; end
    else if (s < umin) begin res = umin; clip = 1'b1; end
  endfunction

  initial begin
    m_u = 0; m_res = 0; m_sat = 0; m_res_sat = 0; m_valid = 0; m_en = 0; m_cnt = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_u = 0; m_sat = 0; m_valid = 0; m_cnt = 0; m_en = 1;
    end else if (clr) begin
      m_u = 0; m_sat = 0; m_valid = 0; m_cnt = 0;
    end else begin
      m_valid = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_u = m_res; m_sat = m_res_sat; m_valid = 1;
        end
      end else if (start) begin
        pid_law(m_u, m_res, m_res_sat);
        m_cnt = LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      check("model_u_out", u_out, m_u);
      check("model_valid", valid, m_valid);
      check("model_busy",  busy,  m_cnt != 0);
      check("model_sat",   sat,   m_sat);
    end
  end

  task automatic set_in(input int e0, input int e1, input int e2, input int p, input int i, input int d);
    ek0 = ERR_W'(e0); ek1 = ERR_W'(e1); ek2 = ERR_W'(e2);
    kp  = K_W'(p);    ki  = K_W'(i);    kd  = K_W'(d);
  endtask

  // Issues a start sampled at E0 and returns at the negedge following E4.
  task automatic run_op(input int e0, input int e1, input int e2, input int p, input int i, input int d);
    @(negedge clk);
    set_in(e0, e1, e2, p, i, d);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_in(-e0, 7, -9, 3, -5, 11);
    repeat (LAT) @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  int vcount;
  int exp_sat[5];

  initial begin
    exp_sat = '{8120, 16240, 24360, 32480, 32767};
    rst = 1'b1; start = 1'b0; clr = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset_u_out", u_out, 0);
    check("reset_valid", valid, 0);
    check("reset_busy",  busy,  0);
    check("reset_sat",   sat,   0);
    rst = 1'b0;

    // P only, with busy tracked across E0..E3
    @(negedge clk);
    set_in(10, 0, 0, 16, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("p_busy_e0", busy, 1);
    repeat (3) @(negedge clk);
    check("p_busy_e3", busy, 1);
    check("p_valid_e3", valid, 0);
    @(negedge clk);
    check("p_valid", valid, 1);
    check("p_u_out", u_out, 10);
    check("p_sat",   sat,   0);
    check("p_busy_e4", busy, 0);
    check("p_model_u", m_u, 10);

    // I term floor rounding
    do_clr();
    run_op(-3, 0, 0, 0, 8, 0);
    check("i_u_out", u_out, -2);
    check("i_model_u", m_u, -2);

    // D term on top of a prior u_out of 10
    do_clr();
    run_op(10, 0, 0, 16, 0, 0);
    run_op(5, 2, 1, 0, 0, 16);
    check("d_u_out", u_out, 12);

    // Saturation over five back-to-back operations
    do_clr();
    for (int k = 0; k < 5; k++) begin
      run_op(511, -512, 0, 127, 0, 0);
      check("sat_valid", valid, 1);
      check("sat_u_out", u_out, exp_sat[k]);
      check("sat_flag",  sat,   k == 4);
    end

    // Second start at E2 is ignored
    do_clr();
    @(negedge clk);
    set_in(10, 0, 0, 16, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    set_in(100, 0, 0, 16, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("busy_start_pulses", vcount, 1);
    check("busy_start_u_out", u_out, 10);

    // rst sampled at E2 aborts
    @(negedge clk);
    set_in(10, 0, 0, 16, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_u_out", u_out, 0);
    check("rst_mid_busy",  busy,  0);
    vcount = 0;
    repeat (5) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("rst_mid_pulses", vcount, 0);

    // clr with simultaneous start
    run_op(10, 0, 0, 16, 0, 0);
    @(negedge clk);
    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    check("clr_start_u_out", u_out, 0);
    check("clr_start_busy",  busy,  0);
    @(negedge clk);
    check("clr_start_busy2", busy,  0);

    // Randomised traffic, operands changing every cycle
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      ek0 = ERR_W'($urandom); ek1 = ERR_W'($urandom); ek2 = ERR_W'($urandom);
      kp  = K_W'($urandom);   ki  = K_W'($urandom);   kd  = K_W'($urandom);
      start = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 40) == 0);
      rst   = ($urandom_range(0, 90) == 0);
    end
    @(negedge clk);
    start = 1'b0; clr = 1'b0; rst = 1'b0;
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
